// File: rtl/pcpi_serial_bridge.sv
// Serial PCPI front-end: gathers SEG_W-bit instruction segments into a WORD_W-bit PCPI request and streams the result back.
// Latency: pcpi_valid rises 1 cycle after the last segment handshake; the first result beat is valid 1 cycle after pcpi_ready.
// Backpressure: seg_ready is high only while loading; result beats are held stable until rd_ready; the PCPI request is held until pcpi_ready or timeout.
module pcpi_serial_bridge #(
   parameter int SEG_W   = 4,
   parameter int WORD_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              seg_valid,
   input  logic [SEG_W-1:0]  seg_data,
   output logic              seg_ready,
   output logic              pcpi_valid,
   output logic [WORD_W-1:0] pcpi_insn,
   input  logic              pcpi_ready,
   input  logic              pcpi_wr,
   input  logic              pcpi_wait,
   input  logic [WORD_W-1:0] pcpi_rd,
   output logic              rd_valid,
   output logic [SEG_W-1:0]  rd_data,
   input  logic              rd_ready,
   output logic              busy,
   output logic              err_timeout
);

   // Number of segments per word and the counter widths that index them.
   localparam int NSEG = WORD_W / SEG_W;
   localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [CW-1:0] SEG_LAST  = CW'(NSEG - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [CW-1:0]      seg_cnt;
   logic [CW-1:0]      beat_cnt;
   logic [TW-1:0]      to_cnt;
   logic [WORD_W-1:0]  shreg;

   // Per-cycle control strobes produced by the next-state logic.
   logic               seg_xfer;
   logic               last_seg;
   logic               capture;
   logic               to_clear;
   logic               to_inc;
   logic               to_hit;
   logic               beat_xfer;
   logic               last_beat;

   // Handshake and status outputs decode directly from the registered state,
   // so pcpi_valid/rd_valid are glitch-free and change one cycle after the
   // event that moves the FSM.
   assign seg_ready  = (state == LOAD) && rst_n;
   assign pcpi_valid = (state == ISSUE);
   assign rd_valid   = (state == DRAIN);
   assign busy       = (state == ISSUE) || (state == DRAIN);
   assign rd_data    = shreg[SEG_W-1:0];

   // State register; reset is synchronous and discards any partial word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and control strobes for the load/issue/drain sequence.
   always_comb begin
      state_nxt = state;
      seg_xfer  = 1'b0;
      last_seg  = 1'b0;
      capture   = 1'b0;
      to_clear  = 1'b0;
      to_inc    = 1'b0;
      to_hit    = 1'b0;
      beat_xfer = 1'b0;
      last_beat = 1'b0;
      case (state)
         LOAD: begin
            seg_xfer = seg_valid && seg_ready;
            if (seg_xfer && (seg_cnt == SEG_LAST)) begin
               last_seg  = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            // Completion has priority over a timeout landing in the same cycle.
            if (pcpi_ready) begin
               if (pcpi_wr) begin
                  capture   = 1'b1;
                  state_nxt = DRAIN;
               end else begin
                  state_nxt = LOAD;
               end
            end else if (pcpi_wait) begin
               to_clear = 1'b1;
            end else if (to_cnt == TO_LAST) begin
               to_hit    = 1'b1;
               state_nxt = LOAD;
            end else begin
               to_inc = 1'b1;
            end
         end
         DRAIN: begin
            if (rd_ready) begin
               beat_xfer = 1'b1;
               if (beat_cnt == SEG_LAST) begin
                  last_beat = 1'b1;
                  state_nxt = LOAD;
               end
            end
         end
         default: begin
            state_nxt = LOAD;
         end
      endcase
   end

   // Segment index: advances per accepted segment, wraps after the last one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_cnt <= '0;
      end else if (seg_xfer) begin
         seg_cnt <= last_seg ? '0 : seg_cnt + CW'(1);
      end
   end

   // Instruction assembly: each segment lands in its own slice, LSB first;
   // the word is left untouched outside LOAD so it stays stable during issue.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcpi_insn <= '0;
      end else if (seg_xfer) begin
         for (int i = 0; i < NSEG; i++) begin
            if (seg_cnt == CW'(i)) begin
               pcpi_insn[i*SEG_W +: SEG_W] <= seg_data;
            end
         end
      end
   end

   // Timeout counter: counts idle issue cycles, restarts on wait and on exit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if (to_clear || (state_nxt != ISSUE)) begin
         to_cnt <= '0;
      end else if (to_inc) begin
         to_cnt <= to_cnt + TW'(1);
      end
   end

   // Sticky timeout flag: set on abort, cleared when the next word starts.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_timeout <= 1'b0;
      end else if (to_hit) begin
         err_timeout <= 1'b1;
      end else if (seg_xfer && (seg_cnt == '0)) begin
         err_timeout <= 1'b0;
      end
   end

   // Result shift register: loaded from pcpi_rd, shifted right per accepted beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg <= '0;
      end else if (capture) begin
         shreg <= pcpi_rd;
      end else if (beat_xfer) begin
         shreg <= {{SEG_W{1'b0}}, shreg[WORD_W-1:SEG_W]};
      end
   end

   // Beat index: counts accepted result beats, wraps after the last one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_cnt <= '0;
      end else if (beat_xfer) begin
         beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_pcpi_serial_bridge.sv
module tb_pcpi_serial_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // SEG_W=4 instance signals
   logic        seg_valid;
   logic [3:0]  seg_data;
   logic        seg_ready;
   logic        pcpi_valid;
   logic [31:0] pcpi_insn;
   logic        pcpi_ready;
   logic        pcpi_wr;
   logic        pcpi_wait;
   logic [31:0] pcpi_rd;
   logic        rd_valid;
   logic [3:0]  rd_data;
   logic        rd_ready;
   logic        busy;
   logic        err_timeout;

   // SEG_W=8 instance signals
   logic        b_seg_valid;
   logic [7:0]  b_seg_data;
   logic        b_seg_ready;
   logic        b_pcpi_valid;
   logic [31:0] b_pcpi_insn;
   logic        b_pcpi_ready;
   logic        b_pcpi_wr;
   logic        b_pcpi_wait;
   logic [31:0] b_pcpi_rd;
   logic        b_rd_valid;
   logic [7:0]  b_rd_data;
   logic        b_rd_ready;
   logic        b_busy;
   logic        b_err_timeout;

   int checks   = 0;
   int failures = 0;

   logic [3:0] exp_q[$];
   logic [7:0] exp8_q[$];

   pcpi_serial_bridge #(.SEG_W(4), .WORD_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .seg_valid(seg_valid), .seg_data(seg_data), .seg_ready(seg_ready),
      .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
      .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr), .pcpi_wait(pcpi_wait), .pcpi_rd(pcpi_rd),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
      .busy(busy), .err_timeout(err_timeout)
   );

   pcpi_serial_bridge #(.SEG_W(8), .WORD_W(32), .TIMEOUT(16)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .seg_valid(b_seg_valid), .seg_data(b_seg_data), .seg_ready(b_seg_ready),
      .pcpi_valid(b_pcpi_valid), .pcpi_insn(b_pcpi_insn),
      .pcpi_ready(b_pcpi_ready), .pcpi_wr(b_pcpi_wr), .pcpi_wait(b_pcpi_wait), .pcpi_rd(b_pcpi_rd),
      .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_ready(b_rd_ready),
      .busy(b_busy), .err_timeout(b_err_timeout)
   );

   // Offers one segment and completes its handshake; returns 1 time unit after the edge.
   task automatic send_seg(input logic [3:0] d);
      seg_valid = 1'b1;
      seg_data  = d;
      @(negedge clk);
      checks++;
      if (seg_ready !== 1'b1) begin
         failures++;
         $display("FAIL send_seg_ready got=%b exp=1", seg_ready);
      end
      @(posedge clk); #1;
      seg_valid = 1'b0;
   endtask

   task automatic load_word(input logic [31:0] w);
      for (int i = 0; i < 8; i++) send_seg(w[i*4 +: 4]);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      seg_valid = 0; seg_data = 0; pcpi_ready = 0; pcpi_wr = 0; pcpi_wait = 0; pcpi_rd = 0; rd_ready = 0;
      b_seg_valid = 0; b_seg_data = 0; b_pcpi_ready = 0; b_pcpi_wr = 0; b_pcpi_wait = 0; b_pcpi_rd = 0; b_rd_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checks++; if (pcpi_valid !== 1'b0) begin failures++; $display("FAIL reset_pcpi_valid got=%b exp=0", pcpi_valid); end
      checks++; if (pcpi_insn !== 32'h0) begin failures++; $display("FAIL reset_pcpi_insn got=%h exp=0", pcpi_insn); end
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
      checks++; if (rd_data !== 4'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
      checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (seg_ready !== 1'b0) begin failures++; $display("FAIL reset_seg_ready got=%b exp=0", seg_ready); end
      checks++; if (b_pcpi_valid !== 1'b0) begin failures++; $display("FAIL reset_b_pcpi_valid got=%b exp=0", b_pcpi_valid); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (seg_ready !== 1'b1) begin failures++; $display("FAIL post_reset_seg_ready got=%b exp=1", seg_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_load_issue();
      logic [3:0] segs[8];
      segs = '{4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0};
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (pcpi_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL load_idle seg=%0d got valid=%b busy=%b exp 0/0", i, pcpi_valid, busy);
         end
         send_seg(segs[i]);
      end
      @(negedge clk);
      checks++; if (pcpi_valid !== 1'b1) begin failures++; $display("FAIL issue_latency got=%b exp=1", pcpi_valid); end
      checks++; if (pcpi_insn !== 32'h0200_0033) begin failures++; $display("FAIL issue_insn got=%h exp=02000033", pcpi_insn); end
      checks++; if (seg_ready !== 1'b0) begin failures++; $display("FAIL issue_seg_ready got=%b exp=0", seg_ready); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL issue_busy got=%b exp=1", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_drain();
      int n;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (pcpi_valid !== 1'b1 || pcpi_insn !== 32'h0200_0033) begin
            failures++;
            $display("FAIL issue_hold cyc=%0d got valid=%b insn=%h exp 1/02000033", i, pcpi_valid, pcpi_insn);
         end
         @(posedge clk); #1;
      end
      pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hDEAD_BEEF;
      exp_q.push_back(4'hF); exp_q.push_back(4'hE); exp_q.push_back(4'hE); exp_q.push_back(4'hB);
      exp_q.push_back(4'hD); exp_q.push_back(4'hA); exp_q.push_back(4'hE); exp_q.push_back(4'hD);
      @(posedge clk); #1;
      pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'h0;
      n = 0;
      while (exp_q.size() > 0 && n < 40) begin
         rd_ready = (n % 2 == 0);
         @(negedge clk);
         checks++;
         if (rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL drain_valid cyc=%0d got=%b exp=1", n, rd_valid);
         end else if (rd_data !== exp_q[0]) begin
            failures++;
            $display("FAIL drain_beat cyc=%0d got=%h exp=%h", n, rd_data, exp_q[0]);
         end
         if (rd_valid === 1'b1 && rd_ready) void'(exp_q.pop_front());
         checks++;
         if (seg_ready !== 1'b0) begin failures++; $display("FAIL drain_seg_ready got=%b exp=0", seg_ready); end
         @(posedge clk); #1;
         n++;
      end
      rd_ready = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_budget got=%0d beats left exp=0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL drain_end_valid got=%b exp=0", rd_valid); end
      checks++; if (seg_ready !== 1'b1) begin failures++; $display("FAIL drain_end_seg_ready got=%b exp=1", seg_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_no_write();
      load_word(32'h0000_00A5);
      pcpi_ready = 1'b1; pcpi_wr = 1'b0; pcpi_rd = 32'h1234_5678;
      @(posedge clk); #1;
      pcpi_ready = 1'b0; pcpi_rd = 32'h0;
      @(negedge clk);
      checks++; if (pcpi_valid !== 1'b0) begin failures++; $display("FAIL nowr_pcpi_valid got=%b exp=0", pcpi_valid); end
      checks++; if (seg_ready !== 1'b1) begin failures++; $display("FAIL nowr_seg_ready got=%b exp=1", seg_ready); end
      checks++; if (pcpi_insn !== 32'h0000_00A5) begin failures++; $display("FAIL nowr_insn_retained got=%h exp=000000a5", pcpi_insn); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd_valid !== 1'b0) begin failures++; $display("FAIL nowr_rd_valid cyc=%0d got=%b exp=0", i, rd_valid); end
         @(posedge clk); #1;
         @(negedge clk);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_timeout();
      int n;
      logic [31:0] w;
      load_word(32'h0000_0077);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (pcpi_valid !== 1'b1) break;
         n++;
         @(posedge clk); #1;
      end
      checks++; if (n != 16) begin failures++; $display("FAIL timeout_cycles got=%0d exp=16", n); end
      checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", err_timeout); end
      // A late pcpi_ready after the abort must not start a drain.
      @(posedge clk); #1;
      pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'h0;
      @(negedge clk);
      checks++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL late_ready got rd_valid=%b busy=%b exp 0/0", rd_valid, busy); end
      checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err_timeout); end
      @(posedge clk); #1;
      // Next word with pcpi_wait held: timeout suspended; first segment clears the flag.
      pcpi_wait = 1'b1;
      w = 32'h0000_000B;
      for (int i = 0; i < 8; i++) begin
         send_seg(w[i*4 +: 4]);
         if (i == 0) begin
            checks++;
            if (err_timeout !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err_timeout); end
         end
      end
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (pcpi_valid === 1'b1) n++;
         @(posedge clk); #1;
      end
      checks++; if (n != 30) begin failures++; $display("FAIL wait_hold got=%0d exp=30", n); end
      pcpi_ready = 1'b1; pcpi_wr = 1'b0;
      @(posedge clk); #1;
      pcpi_ready = 1'b0; pcpi_wait = 1'b0;
      @(negedge clk);
      checks++; if (pcpi_valid !== 1'b0) begin failures++; $display("FAIL wait_done_valid got=%b exp=0", pcpi_valid); end
      checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL wait_err got=%b exp=0", err_timeout); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midload();
      send_seg(4'hF); send_seg(4'hF); send_seg(4'hF);
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (seg_ready !== 1'b0) begin failures++; $display("FAIL midrst_seg_ready got=%b exp=0", seg_ready); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (pcpi_insn !== 32'h0) begin failures++; $display("FAIL midrst_insn got=%h exp=0", pcpi_insn); end
      @(posedge clk); #1;
      load_word(32'h1234_5678);
      @(negedge clk);
      checks++; if (pcpi_valid !== 1'b1) begin failures++; $display("FAIL midrst_valid got=%b exp=1", pcpi_valid); end
      checks++; if (pcpi_insn !== 32'h1234_5678) begin failures++; $display("FAIL midrst_word got=%h exp=12345678", pcpi_insn); end
      @(posedge clk); #1;
      pcpi_ready = 1'b1; pcpi_wr = 1'b0;
      @(posedge clk); #1;
      pcpi_ready = 1'b0;
   endtask

   task automatic test_wide_seg();
      logic [31:0] w;
      int n;
      w = 32'hA1B2_C3D4;
      for (int i = 0; i < 4; i++) begin
         b_seg_valid = 1'b1;
         b_seg_data  = w[i*8 +: 8];
         @(negedge clk);
         checks++; if (b_seg_ready !== 1'b1) begin failures++; $display("FAIL w8_seg_ready got=%b exp=1", b_seg_ready); end
         @(posedge clk); #1;
      end
      b_seg_valid = 1'b0;
      @(negedge clk);
      checks++; if (b_pcpi_valid !== 1'b1) begin failures++; $display("FAIL w8_valid got=%b exp=1", b_pcpi_valid); end
      checks++; if (b_pcpi_insn !== 32'hA1B2_C3D4) begin failures++; $display("FAIL w8_insn got=%h exp=a1b2c3d4", b_pcpi_insn); end
      @(posedge clk); #1;
      b_pcpi_ready = 1'b1; b_pcpi_wr = 1'b1; b_pcpi_rd = 32'h0F0E_0D0C;
      exp8_q.push_back(8'h0C); exp8_q.push_back(8'h0D); exp8_q.push_back(8'h0E); exp8_q.push_back(8'h0F);
      @(posedge clk); #1;
      b_pcpi_ready = 1'b0; b_pcpi_wr = 1'b0; b_pcpi_rd = 32'h0;
      b_rd_ready = 1'b1;
      n = 0;
      while (exp8_q.size() > 0 && n < 20) begin
         @(negedge clk);
         checks++;
         if (b_rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL w8_rd_valid cyc=%0d got=%b exp=1", n, b_rd_valid);
         end else begin
            if (b_rd_data !== exp8_q[0]) begin
               failures++;
               $display("FAIL w8_beat cyc=%0d got=%h exp=%h", n, b_rd_data, exp8_q[0]);
            end
            void'(exp8_q.pop_front());
         end
         @(posedge clk); #1;
         n++;
      end
      b_rd_ready = 1'b0;
      checks++;
      if (exp8_q.size() != 0) begin
         failures++;
         $display("FAIL w8_budget got=%0d beats left exp=0", exp8_q.size());
         exp8_q.delete();
      end
      @(negedge clk);
      checks++; if (b_rd_valid !== 1'b0 || b_seg_ready !== 1'b1) begin failures++; $display("FAIL w8_end got rd_valid=%b seg_ready=%b exp 0/1", b_rd_valid, b_seg_ready); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_load_issue();
      test_drain();
      test_no_write();
      test_timeout();
      test_reset_midload();
      test_wide_seg();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=expired exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
